// File: rtl/rates_byte_packer_pkg.sv
// rates_byte_packer_pkg: shared constants, byte type and keep-mask helper for the rates byte datapath
package rates_byte_packer_pkg;

    localparam int DEFAULT_DATA_WIDTH_IN_BYTES = 4;
    localparam int MAX_BYTES = 64;

    typedef logic [7:0] byte_t;

    function automatic logic [MAX_BYTES-1:0] keep_from_count(input int nbytes);
        logic [MAX_BYTES-1:0] k;
        for (int i = 0; i < MAX_BYTES; i++) k[i] = (i < nbytes);
        return k;
    endfunction

endpackage

// File: rtl/rates_byte_packer_beat_reg.sv
// rates_beat_reg: AXI-stream style output holding register, loads a new beat whenever the slot is free
module rates_beat_reg #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [8*W-1:0] in_data,
    input  logic [W-1:0]   in_keep,
    input  logic           in_last,
    output logic           out_free,
    output logic [8*W-1:0] m_data,
    output logic [W-1:0]   m_keep,
    output logic           m_last,
    output logic           m_valid,
    input  logic           m_ready
);

    assign out_free = !m_valid || m_ready;

    // hold the beat while stalled; on a free slot either take the new beat or go idle
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (out_free) begin
            m_valid <= load;
            if (load) begin
                m_data <= in_data;
                m_keep <= in_keep;
                m_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/rates_byte_packer.sv
// rates_byte_packer: gathers a byte-serial message stream into wide beats with keep and last
module rates_byte_packer
    import rates_byte_packer_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = DEFAULT_DATA_WIDTH_IN_BYTES,
    parameter int MSG_CNT_WIDTH       = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic                             s_last,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0] m_data,
    output logic [DATA_WIDTH_IN_BYTES-1:0]   m_keep,
    output logic                             m_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [MSG_CNT_WIDTH-1:0]         msg_count
);

    localparam int N  = DATA_WIDTH_IN_BYTES;
    localparam int CW = $clog2(N + 1);

    byte_t [N-1:0] acc;
    byte_t [N-1:0] acc_w;
    logic [CW-1:0] cnt;
    logic [CW-1:0] n_w;
    logic [N-1:0]  keep_w;
    logic          rst_q;
    logic          pending;
    logic          p_last;
    logic          in_hs;
    logic          complete;
    logic          load;
    logic          out_free;

    assign s_ready  = !rst_q && !pending;
    assign in_hs    = s_valid && s_ready;
    assign n_w      = cnt + CW'(in_hs);
    assign complete = in_hs && (cnt == CW'(N - 1) || s_last);
    assign load     = (complete || pending) && out_free;
    assign keep_w   = N'(keep_from_count(int'(n_w)));

    // accumulator as it would look with the current byte written into lane cnt
    always_comb begin
        acc_w = acc;
        for (int i = 0; i < N; i++) acc_w[i] = (in_hs && cnt == CW'(i)) ? s_data : acc[i];
    end

    // lane counter, accumulator and pending beat; cleared whenever a beat moves to the output
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q   <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            rst_q <= 1'b0;
            if (load) begin
                acc     <= '0;
                cnt     <= '0;
                pending <= 1'b0;
            end else if (in_hs) begin
                acc     <= acc_w;
                cnt     <= n_w;
                pending <= complete;
                p_last  <= s_last;
            end
        end
    end

    rates_beat_reg #(.W(N)) u_beat_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .in_data  (acc_w),
        .in_keep  (keep_w),
        .in_last  (pending ? p_last : s_last),
        .out_free (out_free),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    // count messages as their final beat is handed downstream
    always_ff @(posedge clk) begin
        if (rst) msg_count <= '0;
        else if (m_valid && m_ready && m_last) msg_count <= msg_count + 1'b1;
    end

endmodule

// File: tb/tb_rates_byte_packer.sv
// tb_rates_byte_packer: directed vectors, corner sequences and randomized traffic against a beat model
module tb_rates_byte_packer;

    localparam int N     = 4;
    localparam int DW    = 8 * N;
    localparam int NV    = 16;
    localparam int NMSG  = 600;
    localparam int LIMIT = 90000;

    typedef struct {
        logic [7:0]    d;
        logic          l;
        logic          v;
        logic [DW-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_keep;
    logic          m_last;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [31:0]   msg_count;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            exp_msgs = 0;
    bit            rnd_on = 1'b0;
    bit            stall_q = 1'b0;
    logic [DW-1:0] hold_d;
    beat_t         exp_q[$];
    beat_t         mon_e;
    vec_t          tbl[NV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    rates_byte_packer #(.DATA_WIDTH_IN_BYTES(N), .MSG_CNT_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .msg_count (msg_count)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int w;
        w = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_wait: s_ready got 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_random();
        for (int m = 0; m < NMSG; m++) begin
            int         len;
            int         n;
            bit         acc;
            beat_t      e;
            logic [7:0] bytes[$];
            len = $urandom_range(1, 64);
            bytes.delete();
            for (int k = 0; k < len; k++) bytes.push_back(8'($urandom));
            for (int b = 0; b < len; b += N) begin
                n = (len - b < N) ? len - b : N;
                e.data = '0;
                for (int k = 0; k < n; k++) e.data[k*8 +: 8] = bytes[b+k];
                e.keep = N'((1 << n) - 1);
                e.last = (b + n == len);
                exp_q.push_back(e);
            end
            for (int j = 0; j < len; j++) begin
                acc    = 1'b0;
                s_data = bytes[j];
                s_last = (j == len - 1);
                while (!acc && cyc < LIMIT) begin
                    s_valid = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    acc = s_valid && s_ready;
                    @(posedge clk);
                    #1;
                end
            end
            s_valid = 1'b0;
        end
    endtask

    // random downstream backpressure while the random phase is active
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) m_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // scoreboard: every out-handshake must match the model, stalled beats must hold still
    always @(negedge clk) begin
        if (rnd_on) begin
            if (stall_q) begin
                chk("hold_valid", 64'(m_valid), 64'(1));
                chk("hold_data", 64'(m_data), 64'(hold_d));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rnd_extra_beat: got data %0h expected no beat", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rnd_data", 64'(m_data), 64'(mon_e.data));
                    chk("rnd_keep", 64'(m_keep), 64'(mon_e.keep));
                    chk("rnd_last", 64'(m_last), 64'(mon_e.last));
                end
            end
            stall_q = m_valid && !m_ready;
            hold_d  = m_data;
        end
    end

    initial begin
        tbl[0]  = '{8'h01, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
        tbl[1]  = '{8'h02, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
        tbl[2]  = '{8'h03, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
        tbl[3]  = '{8'h04, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0};
        tbl[4]  = '{8'h05, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
        tbl[5]  = '{8'h06, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
        tbl[6]  = '{8'h07, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
        tbl[7]  = '{8'h08, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b1};
        tbl[8]  = '{8'hAA, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
        tbl[9]  = '{8'hBB, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
        tbl[10] = '{8'hCC, 1'b1, 1'b1, 32'h00CCBBAA, 4'h7, 1'b1};
        tbl[11] = '{8'h11, 1'b1, 1'b1, 32'h00000011, 4'h1, 1'b1};
        tbl[12] = '{8'h22, 1'b1, 1'b1, 32'h00000022, 4'h1, 1'b1};
        tbl[13] = '{8'h33, 1'b1, 1'b1, 32'h00000033, 4'h1, 1'b1};
        tbl[14] = '{8'hDD, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
        tbl[15] = '{8'hEE, 1'b1, 1'b1, 32'h0000EEDD, 4'h3, 1'b1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_m_keep", 64'(m_keep), 64'(0));
        chk("rst_m_last", 64'(m_last), 64'(0));
        chk("rst_msg_count", 64'(msg_count), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", 64'(s_ready), 64'(1));

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = tbl[i].d;
            s_last  = tbl[i].l;
            chk("tbl_s_ready", 64'(s_ready), 64'(1));
            @(posedge clk);
            #1;
            chk("tbl_m_valid", 64'(m_valid), 64'(tbl[i].v));
            if (tbl[i].v) begin
                chk("tbl_m_data", 64'(m_data), 64'(tbl[i].data));
                chk("tbl_m_keep", 64'(m_keep), 64'(tbl[i].keep));
                chk("tbl_m_last", 64'(m_last), 64'(tbl[i].last));
                if (tbl[i].last) exp_msgs++;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("tbl_msg_count", 64'(msg_count), 64'(exp_msgs));

        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(16 + i), i == 7);
        chk("bp_s_ready_low", 64'(s_ready), 64'(0));
        chk("bp_m_valid", 64'(m_valid), 64'(1));
        chk("bp_first_beat", 64'(m_data), 64'(32'h13121110));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_valid", 64'(m_valid), 64'(1));
        chk("bp_hold_data", 64'(m_data), 64'(32'h13121110));
        chk("bp_hold_s_ready", 64'(s_ready), 64'(0));
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_second_beat", 64'(m_data), 64'(32'h17161514));
        chk("bp_second_keep", 64'(m_keep), 64'(4'hF));
        chk("bp_second_last", 64'(m_last), 64'(1));
        chk("bp_s_ready_back", 64'(s_ready), 64'(1));
        @(posedge clk);
        #1;
        chk("bp_drained", 64'(m_valid), 64'(0));
        chk("bp_msg_count", 64'(msg_count), 64'(exp_msgs + 1));

        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_m_valid", 64'(m_valid), 64'(0));
        chk("mid_rst_m_data", 64'(m_data), 64'(0));
        chk("mid_rst_m_keep", 64'(m_keep), 64'(0));
        chk("mid_rst_msg_count", 64'(msg_count), 64'(0));
        chk("mid_rst_s_ready", 64'(s_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        send(8'hB4, 1'b1);
        chk("mid_rst_clean_valid", 64'(m_valid), 64'(1));
        chk("mid_rst_clean_data", 64'(m_data), 64'(32'hB4B3B2B1));
        chk("mid_rst_clean_keep", 64'(m_keep), 64'(4'hF));
        chk("mid_rst_clean_last", 64'(m_last), 64'(1));
        @(posedge clk);
        #1;
        chk("mid_rst_msg_count_after", 64'(msg_count), 64'(1));

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rnd_on = 1'b1;
        run_random();
        while (exp_q.size() != 0 && cyc < LIMIT) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rnd_timeout: got %0d beats outstanding expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
        rnd_on  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rnd_msg_count", 64'(msg_count), 64'(NMSG));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
